// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stop polarity, zero word,
// default exception vector, stall vector encodings and FSM state encoding.
// Stall bit 0 is the PC stage, bit 5 is WB; a 1 stops that stage.
package pipe_ctrl_pkg;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [31:0] ExcVectorDefault = 32'hBFC0_0380;

    // Stopping a stage also stops every stage upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StFlush = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline sequencer and the pipeline stages.
//   stallreq_*      : per-stage stall requests (IF, ID, EX, MEM)
//   i_except_valid  : MEM instruction raises an exception
//   i_eret          : MEM instruction is ERET
//   i_cp0_epc       : current EPC, ERET target
//   if_busy         : IF bus transaction outstanding
//   stall, flush    : stage register controls
//   new_pc          : redirect target, valid while flush is high
//   o_exc_commit    : CP0 records exception (with flush)
//   o_eret_commit   : CP0 clears EXL (with flush)
//   o_stall_cycles  : saturating stalled-cycle count
// master: the sequencer side; slave: the pipeline side.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             i_except_valid;
    logic             i_eret;
    logic [31:0]      i_cp0_epc;
    logic             if_busy;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             o_exc_commit;
    logic             o_eret_commit;
    logic [CNT_W-1:0] o_stall_cycles;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  i_except_valid, i_eret, i_cp0_epc, if_busy,
        output stall, flush, new_pc, o_exc_commit, o_eret_commit, o_stall_cycles
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output i_except_valid, i_eret, i_cp0_epc, if_busy,
        input  stall, flush, new_pc, o_exc_commit, o_eret_commit, o_stall_cycles
    );

endinterface

// File: rtl/pipe_stall_enc.sv
// Priority encoder from the four stage stall requests to the stall vector.
// The most downstream requesting stage wins.
//   stallreq_if/id/ex/mem : stage stall requests
//   stall                 : encoded per-stage stop vector
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    output logic [5:0] stall
);

    always_comb begin
        stall = STALL_NONE;
        if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (stallreq_ex) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end else if (stallreq_if) begin
            stall = STALL_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 6-stage core. Produces the stall vector
// and the one-cycle flush pulse, resolves exception/ERET from MEM into a
// redirect, and keeps the pipeline frozen while an IF bus transaction drains.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pipe_ctrl_if master modport (requests in, controls out)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = ExcVectorDefault,
    parameter int unsigned CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    pipe_ctrl_if.master   bus
);

    state_e           state_q, state_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic             pend_eret_q, pend_eret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0]  enc_stall;
    logic        event_valid;
    logic [5:0]  stall_raw;
    logic        flush_raw;
    logic [31:0] new_pc_raw;
    logic        exc_commit_raw;
    logic        eret_commit_raw;

    pipe_stall_enc u_stall_enc (
        .stallreq_if  (bus.stallreq_if),
        .stallreq_id  (bus.stallreq_id),
        .stallreq_ex  (bus.stallreq_ex),
        .stallreq_mem (bus.stallreq_mem),
        .stall        (enc_stall)
    );

    assign event_valid = bus.i_except_valid | bus.i_eret;

    always_comb begin
        state_d         = state_q;
        pend_pc_d       = pend_pc_q;
        pend_eret_d     = pend_eret_q;
        stall_raw       = STALL_NONE;
        flush_raw       = NoStop;
        new_pc_raw      = ZeroWord;
        exc_commit_raw  = 1'b0;
        eret_commit_raw = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (event_valid) begin
                    stall_raw = STALL_ALL;
                    // Exception wins over a simultaneous ERET.
                    pend_pc_d   = bus.i_except_valid ? EXC_VECTOR : bus.i_cp0_epc;
                    pend_eret_d = ~bus.i_except_valid;
                    state_d     = bus.if_busy ? StDrain : StFlush;
                end else begin
                    stall_raw = enc_stall;
                end
            end
            StDrain: begin
                // An abandoned IF bus transaction would corrupt the bus; wait it out.
                stall_raw = STALL_ALL;
                if (!bus.if_busy) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                flush_raw       = Stop;
                new_pc_raw      = pend_pc_q;
                exc_commit_raw  = ~pend_eret_q;
                eret_commit_raw = pend_eret_q;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are forced idle while reset is held so nothing downstream acts
    // on a request that arrives during reset.
    assign bus.stall          = reset ? STALL_NONE : stall_raw;
    assign bus.flush          = reset ? 1'b0       : flush_raw;
    assign bus.new_pc         = reset ? ZeroWord   : new_pc_raw;
    assign bus.o_exc_commit   = reset ? 1'b0       : exc_commit_raw;
    assign bus.o_eret_commit  = reset ? 1'b0       : eret_commit_raw;
    assign bus.o_stall_cycles = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if ((stall_raw != STALL_NONE) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pend_pc_q   <= ZeroWord;
            pend_eret_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            pend_eret_q <= pend_eret_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed per-cycle vectors push their expected outputs
// into a scoreboard queue; a monitor on the falling edge pops and compares.
// A second instance with a 3-bit counter shares the stimulus to exercise
// counter saturation.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(32)) bus ();
    pipe_ctrl_if #(.CNT_W(3))  bus_s ();

    assign bus_s.stallreq_if    = bus.stallreq_if;
    assign bus_s.stallreq_id    = bus.stallreq_id;
    assign bus_s.stallreq_ex    = bus.stallreq_ex;
    assign bus_s.stallreq_mem   = bus.stallreq_mem;
    assign bus_s.i_except_valid = bus.i_except_valid;
    assign bus_s.i_eret         = bus.i_eret;
    assign bus_s.i_cp0_epc      = bus.i_cp0_epc;
    assign bus_s.if_busy        = bus.if_busy;

    pipe_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipe_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .CNT_W(3)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        exc;
        logic        eret;
        logic [31:0] cnt;
        logic [2:0]  cnt_s;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_cnt   = 32'd0;
    logic [2:0]  m_cnt_s = 3'd0;

    task automatic chk(input string nm, input string field, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h", nm, field, got, want);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "stall",  {26'd0, bus.stall},       {26'd0, e.stall});
                chk(e.name, "flush",  {31'd0, bus.flush},       {31'd0, e.flush});
                chk(e.name, "new_pc", bus.new_pc,               e.new_pc);
                chk(e.name, "exc",    {31'd0, bus.o_exc_commit},  {31'd0, e.exc});
                chk(e.name, "eret",   {31'd0, bus.o_eret_commit}, {31'd0, e.eret});
                chk(e.name, "cnt",    bus.o_stall_cycles,       e.cnt);
                chk(e.name, "cnt_s",  {29'd0, bus_s.o_stall_cycles}, {29'd0, e.cnt_s});
            end
        end
    end

    // req = {mem, ex, id, if}
    task automatic step(input string nm, input logic rst, input logic [3:0] req,
                        input logic exc, input logic er, input logic [31:0] epc,
                        input logic busy, input logic [5:0] s, input logic f,
                        input logic [31:0] pc, input logic xc, input logic ec);
        exp_t e;
        reset              = rst;
        bus.stallreq_if    = req[0];
        bus.stallreq_id    = req[1];
        bus.stallreq_ex    = req[2];
        bus.stallreq_mem   = req[3];
        bus.i_except_valid = exc;
        bus.i_eret         = er;
        bus.i_cp0_epc      = epc;
        bus.if_busy        = busy;
        e.name   = nm;
        e.stall  = s;
        e.flush  = f;
        e.new_pc = pc;
        e.exc    = xc;
        e.eret   = ec;
        e.cnt    = m_cnt;
        e.cnt_s  = m_cnt_s;
        sb.push_back(e);
        if (rst) begin
            m_cnt   = 32'd0;
            m_cnt_s = 3'd0;
        end else if (s != 6'd0) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_cnt_s != 3'd7) m_cnt_s = m_cnt_s + 3'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset              = 1'b1;
        bus.stallreq_if    = 1'b1;
        bus.stallreq_id    = 1'b1;
        bus.stallreq_ex    = 1'b1;
        bus.stallreq_mem   = 1'b1;
        bus.i_except_valid = 1'b1;
        bus.i_eret         = 1'b1;
        bus.i_cp0_epc      = 32'h8000_1234;
        bus.if_busy        = 1'b1;
        @(posedge clk);
        #1;
        //   name       rst req      exc er  epc           busy stall     fl pc            xc ec
        step("rst0",    1, 4'b1111, 1, 1, 32'h8000_1234, 1, 6'b000000, 0, 32'h0,        0, 0);
        step("rst1",    1, 4'b1111, 1, 1, 32'h8000_1234, 1, 6'b000000, 0, 32'h0,        0, 0);
        step("idle",    0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        step("ex",      0, 4'b0100, 0, 0, 32'h0,         0, 6'b001111, 0, 32'h0,        0, 0);
        step("ex_mem",  0, 4'b1100, 0, 0, 32'h0,         0, 6'b011111, 0, 32'h0,        0, 0);
        step("if",      0, 4'b0001, 0, 0, 32'h0,         0, 6'b000011, 0, 32'h0,        0, 0);
        step("id_if",   0, 4'b0011, 0, 0, 32'h0,         0, 6'b000111, 0, 32'h0,        0, 0);
        step("none",    0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        // Exception with IF idle; new event and stall request ignored in FLUSH.
        step("exc_t",   0, 4'b0000, 1, 0, 32'h0,         0, 6'b111111, 0, 32'h0,        0, 0);
        step("exc_t1",  0, 4'b1000, 1, 0, 32'h0,         0, 6'b000000, 1, 32'hBFC00380, 1, 0);
        step("exc_t2",  0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        // ERET while IF busy; an exception arriving in DRAIN is ignored.
        step("eret_t",  0, 4'b0000, 0, 1, 32'h8000_1234, 1, 6'b111111, 0, 32'h0,        0, 0);
        step("eret_t1", 0, 4'b0100, 0, 0, 32'h0,         1, 6'b111111, 0, 32'h0,        0, 0);
        step("eret_t2", 0, 4'b0000, 1, 0, 32'h0,         0, 6'b111111, 0, 32'h0,        0, 0);
        step("eret_t3", 0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 1, 32'h80001234, 0, 1);
        step("eret_t4", 0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        // Simultaneous exception and ERET: exception wins.
        step("both_t",  0, 4'b0000, 1, 1, 32'h8000_1234, 0, 6'b111111, 0, 32'h0,        0, 0);
        step("both_t1", 0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 1, 32'hBFC00380, 1, 0);
        step("both_t2", 0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        // Reset while draining discards the pending event.
        step("rd_t",    0, 4'b0000, 1, 0, 32'h0,         1, 6'b111111, 0, 32'h0,        0, 0);
        step("rd_t1",   0, 4'b0000, 0, 0, 32'h0,         1, 6'b111111, 0, 32'h0,        0, 0);
        step("rd_rst",  1, 4'b0000, 0, 0, 32'h0,         1, 6'b000000, 0, 32'h0,        0, 0);
        step("rd_t3",   0, 4'b0000, 0, 0, 32'h0,         1, 6'b000000, 0, 32'h0,        0, 0);
        step("rd_t4",   0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        step("rd_t5",   0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        step("post_ex", 0, 4'b0100, 0, 0, 32'h0,         0, 6'b001111, 0, 32'h0,        0, 0);
        step("end",     0, 4'b0000, 0, 0, 32'h0,         0, 6'b000000, 0, 32'h0,        0, 0);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
